// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - saturating frame accumulator for the Dadda multiplier product stream
module product_accumulator #(
    parameter int ACC_W   = 12,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       prod_in,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             out_forced,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] SUM_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    logic [ACC_W:0]   nsum;
    logic             ovf;
    logic [ACC_W-1:0] sum_clamped;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             close_frame;

    // One spare bit on the adder exposes the overflow; a saturated acc stays at SUM_MAX.
    always_comb begin
        nsum        = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod_in};
        ovf         = nsum[ACC_W];
        sum_clamped = ovf ? SUM_MAX : nsum[ACC_W-1:0];
        cnt_next    = cnt + CNT_W'(1);
        accept      = in_valid && in_ready;
        close_frame = accept && (in_last || (cnt == LAST_CNT));
    end

    assign in_ready  = (state == ACCUM) && !rst;
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCUM;
            acc        <= '0;
            cnt        <= '0;
            sat        <= 1'b0;
            out_sum    <= '0;
            out_count  <= '0;
            out_sat    <= 1'b0;
            out_forced <= 1'b0;
        end else if (state == ACCUM) begin
            if (close_frame) begin
                out_sum    <= sum_clamped;
                out_count  <= cnt_next;
                out_sat    <= sat | ovf;
                out_forced <= !in_last;
                acc        <= '0;
                cnt        <= '0;
                sat        <= 1'b0;
                state      <= HOLD;
            end else if (accept) begin
                acc <= sum_clamped;
                cnt <= cnt_next;
                sat <= sat | ovf;
            end
        end else if (out_ready) begin
            state <= ACCUM;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator at two parameter sets
module tb_product_accumulator;

    localparam int AW0 = 12;
    localparam int ML0 = 4;
    localparam int CW0 = $clog2(ML0 + 1);
    localparam int AW1 = 8;
    localparam int ML1 = 16;
    localparam int CW1 = $clog2(ML1 + 1);

    typedef struct {
        int sum;
        int count;
        int sat;
        int forced;
    } result_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     prod_in;
    logic           in_valid;
    logic           in_last;
    logic           out_ready;
    logic           in_ready0, in_ready1;
    logic           out_valid0, out_valid1;
    logic           out_sat0, out_sat1;
    logic           out_forced0, out_forced1;
    logic [AW0-1:0] out_sum0;
    logic [AW1-1:0] out_sum1;
    logic [CW0-1:0] out_count0;
    logic [CW1-1:0] out_count1;

    int checks = 0;
    int errors = 0;
    result_t sb0[$];
    result_t sb1[$];

    int m_acc[2];
    int m_cnt[2];
    int m_sat[2];
    int m_hold[2];
    int m_sum[2];
    int m_count[2];
    int m_osat[2];
    int m_forced[2];
    int acc_max[2] = '{(1 << AW0) - 1, (1 << AW1) - 1};
    int max_len[2] = '{ML0, ML1};

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(AW0), .MAX_LEN(ML0)) dut0 (
        .clk(clk), .rst(rst), .prod_in(prod_in), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready0), .out_sum(out_sum0), .out_count(out_count0), .out_sat(out_sat0),
        .out_forced(out_forced0), .out_valid(out_valid0), .out_ready(out_ready)
    );

    product_accumulator #(.ACC_W(AW1), .MAX_LEN(ML1)) dut1 (
        .clk(clk), .rst(rst), .prod_in(prod_in), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready1), .out_sum(out_sum1), .out_count(out_count1), .out_sat(out_sat1),
        .out_forced(out_forced1), .out_valid(out_valid1), .out_ready(out_ready)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_acc[d]    = 0;
        m_cnt[d]    = 0;
        m_sat[d]    = 0;
        m_hold[d]   = 0;
        m_sum[d]    = 0;
        m_count[d]  = 0;
        m_osat[d]   = 0;
        m_forced[d] = 0;
    endtask

    task automatic model_step(input int d);
        result_t r;
        int nsum;
        int ov;
        if (rst) begin
            if (m_hold[d] != 0) begin
                if (d == 0 && sb0.size() > 0) void'(sb0.pop_back());
                if (d == 1 && sb1.size() > 0) void'(sb1.pop_back());
            end
            model_reset(d);
        end else if (m_hold[d] != 0) begin
            if (out_ready) m_hold[d] = 0;
        end else if (in_valid) begin
            nsum = m_acc[d] + int'(prod_in);
            ov   = (nsum > acc_max[d]) ? 1 : 0;
            if (ov != 0) nsum = acc_max[d];
            if (in_last || (m_cnt[d] + 1 == max_len[d])) begin
                r.sum       = nsum;
                r.count     = m_cnt[d] + 1;
                r.sat       = m_sat[d] | ov;
                r.forced    = in_last ? 0 : 1;
                m_sum[d]    = r.sum;
                m_count[d]  = r.count;
                m_osat[d]   = r.sat;
                m_forced[d] = r.forced;
                m_acc[d]    = 0;
                m_cnt[d]    = 0;
                m_sat[d]    = 0;
                m_hold[d]   = 1;
                if (d == 0) sb0.push_back(r);
                else sb1.push_back(r);
            end else begin
                m_acc[d] = nsum;
                m_cnt[d] = m_cnt[d] + 1;
                m_sat[d] = m_sat[d] | ov;
            end
        end
    endtask

    task automatic sample(input int d);
        result_t r;
        int rdy, vld, s, c, st, f;
        if (d == 0) begin
            rdy = int'(in_ready0); vld = int'(out_valid0); s = int'(out_sum0);
            c = int'(out_count0); st = int'(out_sat0); f = int'(out_forced0);
        end else begin
            rdy = int'(in_ready1); vld = int'(out_valid1); s = int'(out_sum1);
            c = int'(out_count1); st = int'(out_sat1); f = int'(out_forced1);
        end
        check($sformatf("d%0d_in_ready", d), rdy, (!rst && m_hold[d] == 0) ? 1 : 0);
        check($sformatf("d%0d_out_valid", d), vld, m_hold[d]);
        check($sformatf("d%0d_out_sum_reg", d), s, m_sum[d]);
        check($sformatf("d%0d_out_count_reg", d), c, m_count[d]);
        check($sformatf("d%0d_out_sat_reg", d), st, m_osat[d]);
        check($sformatf("d%0d_out_forced_reg", d), f, m_forced[d]);
        if (vld != 0 && out_ready && !rst) begin
            if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                check($sformatf("d%0d_unexpected_result", d), 1, 0);
            end else begin
                r = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                check($sformatf("d%0d_sb_sum", d), s, r.sum);
                check($sformatf("d%0d_sb_count", d), c, r.count);
                check($sformatf("d%0d_sb_sat", d), st, r.sat);
                check($sformatf("d%0d_sb_forced", d), f, r.forced);
            end
        end
    endtask

    task automatic cyc(input logic r, input logic v, input int p, input logic l, input logic o);
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        prod_in   = 8'(p);
        in_last   = l;
        out_ready = o;
        #1;
        sample(0);
        sample(1);
        @(posedge clk);
        model_step(0);
        model_step(1);
    endtask

    task automatic beat(input int p, input logic l);
        cyc(1'b0, 1'b1, p, l, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        prod_in   = 8'd0;
        out_ready = 1'b1;
        model_reset(0);
        model_reset(1);
        @(posedge clk);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
        idle(1);

        // basic frame: 225 + 12 + 1
        beat(225, 1'b0); beat(12, 1'b0); beat(1, 1'b1);
        idle(2);

        // bubbles then backpressure held for five cycles
        beat(9, 1'b0); idle(1); beat(0, 1'b0);
        cyc(1'b0, 1'b1, 6, 1'b1, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 50, 1'b0, 1'b1);
        beat(50, 1'b1);
        idle(2);

        // forced close on dut0, then a frame whose last beat hits MAX_LEN
        repeat (4) beat(100, 1'b0);
        idle(1);
        repeat (3) beat(100, 1'b0);
        beat(100, 1'b1);
        idle(2);

        // saturation then a clean follow-up frame
        beat(200, 1'b0); beat(100, 1'b0); beat(5, 1'b1);
        idle(1);
        beat(7, 1'b1);
        idle(2);

        // single-beat frames, back to back
        beat(0, 1'b1);
        idle(1);
        for (int i = 0; i < 8; i++) beat(i * 30, 1'b1);
        idle(2);

        // randomized traffic with random backpressure
        repeat (60) cyc(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 225),
                        $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
        idle(3);
        beat(1, 1'b1);
        idle(2);

        // reset mid-frame
        beat(10, 1'b0); beat(20, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
        idle(2);

        // reset while holding a result
        cyc(1'b0, 1'b1, 5, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
        idle(2);
        beat(3, 1'b1);
        idle(3);

        check("d0_sb_leftover", sb0.size(), 0);
        check("d1_sb_leftover", sb1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream stage of the 4x4 Dadda multiplier. It consumes the multiplier's 8-bit unsigned product stream under a valid/ready handshake and accumulates products over a frame, forming a dot product. At frame end it presents the saturated sum, the beat count and status flags on an output valid/ready handshake. It turns the combinational multiplier into a sequential multiply-accumulate datapath.

## Interface
- ACC_W, 12, accumulator and output sum width in bits; legal range 8..24.
- MAX_LEN, 16, maximum beats per frame; a frame is force-closed on its MAX_LEN-th accepted beat.
- CNT_W, $clog2(MAX_LEN+1), derived; width of the beat counter and out_count.

- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- prod_in  input  8  unsigned product from the Dadda multiplier (0..225).
- in_valid  input  1  prod_in and in_last are valid.
- in_last  input  1  current beat closes the frame.
- in_ready  output  1  stage accepts a beat this cycle.
- out_sum  output  ACC_W  frame sum, saturated at 2^ACC_W-1.
- out_count  output  CNT_W  number of beats in the frame (1..MAX_LEN).
- out_sat  output  1  saturation occurred somewhere in the frame.
- out_forced  output  1  frame was closed by MAX_LEN, not by in_last.
- out_valid  output  1  result outputs valid.
- out_ready  input  1  downstream accepts the result.

## Operation
- Two states: ACCUM and HOLD.
- Reset state is ACCUM. Reset values: acc=0, cnt=0, sat=0, out_sum=0, out_count=0, out_sat=0, out_forced=0, out_valid=0.
- in_ready = (state==ACCUM) && !rst.
- out_valid = (state==HOLD).
- A beat is accepted when in_valid && in_ready.
- On each accepted beat:
  - nsum = acc + zero-extended prod_in, computed ACC_W+1 bits wide.
  - If nsum > 2^ACC_W-1, clamp to 2^ACC_W-1 and set sat.
  - Once saturated, the sum stays clamped (saturating add) for the rest of the frame.
  - cnt increments.
- Frame close: an accepted beat with in_last=1, or an accepted beat where cnt+1==MAX_LEN.
  - Load out_sum with the clamped nsum.
  - Load out_count with cnt+1.
  - Load out_sat with sat OR this beat's overflow.
  - Load out_forced = (in_last==0).
  - Clear acc, cnt and sat; go to HOLD.
- If in_last=1 coincides with the MAX_LEN-th beat, the close is treated as normal: out_forced=0.
- HOLD:
  - Outputs are stable while out_valid=1 and out_ready=0.
  - prod_in and in_last are ignored.
  - When out_ready=1, return to ACCUM next cycle.
- in_valid=0 cycles inside a frame leave all state unchanged (bubbles allowed).
- rst mid-frame or in HOLD: the partial frame or pending result is discarded and all registers return to their reset values. No output is produced for that frame.

## Timing
- Accumulate throughput: 1 beat per cycle in ACCUM.
- Latency: out_valid rises on the cycle after the closing beat is accepted.
- Minimum HOLD duration is 1 cycle. With out_ready held high, in_ready is low for exactly one cycle between frames.
- The first beat of the next frame can be accepted on the cycle after the out_valid&&out_ready handshake.
- in_ready is a function of registered state only; there is no combinational path from out_ready to in_ready.
- Outputs are driven directly from registers.

## Test plan
- Basic frame: ACC_W=12. Beats 225, 12, 1 with in_last on the 3rd, out_ready=1 → out_valid one cycle after the 3rd beat with out_sum=238, out_count=3, out_sat=0, out_forced=0. in_ready is low for 1 cycle.
- Backpressure and bubbles: beats 9, 0, 6 with an in_valid=0 gap after the first, in_last on 6, out_ready=0 for 5 cycles → out_sum=15 held stable and in_ready=0 throughout. Release out_ready → ACCUM on the next cycle, and the next frame's first beat is accepted.
- Forced close: MAX_LEN=4, four beats of 100 with in_last=0 → out_sum=400, out_count=4, out_forced=1. The 5th beat starts a new frame. Second case: in_last=1 on the 4th beat → out_forced=0.
- Saturation: ACC_W=8. Beats 200, 100, 5 with last → out_sum=255, out_sat=1. The next frame with a single beat 7 → out_sum=7, out_sat=0.
- Single-beat frame: beat 0 with in_last → out_sum=0, out_count=1. Back-to-back single-beat frames under continuous out_ready → one result every 2 cycles.
- Reset mid-operation: rst asserted after 2 beats of a frame, and separately in HOLD → all outputs at reset values the cycle after rst, no result emitted, in_ready=1 the cycle after rst deasserts.
